// File: rtl/dec_skid.sv
// rtl/dec_skid.sv - registered binary-to-one-hot decoder with a 2-entry skid buffer
// Decode happens at the input; OUT and SKD hold {err, one-hot} so outputs come straight from flops.
module dec_skid #(
  parameter int W = 8,
  localparam int IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [IW-1:0] i_x,
  output logic          o_ready,
  output logic          o_valid,
  output logic [W-1:0]  o_y,
  output logic          o_err,
  input  logic          i_ready,
  output logic [1:0]    o_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam logic [IW:0] W_ENC = (IW+1)'(W);

  state_t     state_q, state_d;
  logic [W:0] out_q, out_d;
  logic [W:0] skd_q, skd_d;
  logic       valid_q, valid_d;
  logic       ready_q, ready_d;
  logic [1:0] count_q, count_d;
  logic       in_acc, out_acc;
  logic [W:0] dec;

  function automatic logic [W:0] decode(input logic [IW-1:0] idx);
    logic [W:0] r;
    r = '0;
    for (int k = 0; k < W; k++) begin
      r[k] = ({1'b0, idx} == (IW+1)'(k));
    end
    r[W] = ({1'b0, idx} >= W_ENC);
    return r;
  endfunction

  always_comb begin
    in_acc  = i_valid & ready_q;
    out_acc = valid_q & i_ready;
    dec     = decode(i_x);
    state_d = state_q;
    out_d   = out_q;
    skd_d   = skd_q;
    case (state_q)
      EMPTY: begin
        if (in_acc) begin
          out_d   = dec;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_acc && !out_acc) begin
          skd_d   = dec;
          state_d = FULL;
        end else if (in_acc && out_acc) begin
          out_d = dec;
        end else if (out_acc) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Ready is low here, so only a pop can happen.
        if (out_acc) begin
          out_d   = skd_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != FULL);
    count_d = (state_d == FULL) ? 2'd2 : (state_d == ONE) ? 2'd1 : 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skd_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skd_q   <= skd_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      count_q <= count_d;
    end
  end

  assign o_valid = valid_q;
  assign o_ready = ready_q;
  assign o_count = count_q;
  assign o_y     = out_q[W-1:0];
  assign o_err   = out_q[W];

endmodule

// File: tb/tb_dec_skid.sv
// tb/tb_dec_skid.sv - randomized and directed bench for dec_skid at W=8 and W=6
// A depth-2 FIFO of expected {err, vector} per instance serves as the reference.
module tb_dec_skid;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [2:0] i_x = '0;
  logic       i_ready = 1'b0;

  logic       o_ready8, o_valid8, o_err8;
  logic [7:0] o_y8;
  logic [1:0] o_count8;
  logic       o_ready6, o_valid6, o_err6;
  logic [5:0] o_y6;
  logic [1:0] o_count6;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] q8[$];
  logic [8:0] q6[$];

  always #5 clk = ~clk;

  dec_skid #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_x(i_x), .o_ready(o_ready8),
    .o_valid(o_valid8), .o_y(o_y8), .o_err(o_err8), .i_ready(i_ready), .o_count(o_count8)
  );

  dec_skid #(.W(6)) dut6 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_x(i_x), .o_ready(o_ready6),
    .o_valid(o_valid6), .o_y(o_y6), .o_err(o_err6), .i_ready(i_ready), .o_count(o_count6)
  );

  // Expected {err, vector} for width w: bit idx set when in range, else err alone.
  function automatic logic [8:0] expect_dec(input int w, input int idx);
    logic [8:0] r;
    r = '0;
    if (idx < w) r[idx] = 1'b1;
    else r[8] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q8.delete();
      q6.delete();
    end else begin
      automatic bit in8  = i_valid && (q8.size() < 2);
      automatic bit out8 = (q8.size() > 0) && i_ready;
      automatic bit in6  = i_valid && (q6.size() < 2);
      automatic bit out6 = (q6.size() > 0) && i_ready;
      if (out8) void'(q8.pop_front());
      if (in8) q8.push_back(expect_dec(8, int'(i_x)));
      if (out6) void'(q6.pop_front());
      if (in6) q6.push_back(expect_dec(6, int'(i_x)));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid8", {31'b0, o_valid8}, {31'b0, q8.size() > 0});
      chk("ready8", {31'b0, o_ready8}, {31'b0, q8.size() < 2});
      chk("count8", {30'b0, o_count8}, 32'(q8.size()));
      if (q8.size() > 0) chk("data8", {23'b0, o_err8, o_y8}, {23'b0, q8[0]});
      if (o_valid8) chk("onehot8", {31'b0, $onehot(o_y8) || (o_err8 && o_y8 == 0)}, 32'd1);
      chk("valid6", {31'b0, o_valid6}, {31'b0, q6.size() > 0});
      chk("ready6", {31'b0, o_ready6}, {31'b0, q6.size() < 2});
      chk("count6", {30'b0, o_count6}, 32'(q6.size()));
      if (q6.size() > 0) chk("data6", {25'b0, o_err6, o_y6}, {23'b0, q6[0][8], 2'b0, q6[0][5:0]} & 32'h7f | {25'b0, q6[0][8], 6'b0});
      if (o_valid6) chk("onehot6", {31'b0, $onehot(o_y6) || (o_err6 && o_y6 == 0)}, 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    chk("rst_valid", {31'b0, o_valid8}, 32'd0);
    chk("rst_y", {24'b0, o_y8}, 32'd0);
    chk("rst_ready", {31'b0, o_ready8}, 32'd1);
    chk("rst_count", {30'b0, o_count8}, 32'd0);
    rst = 1'b0;
    step();

    // Single index 5
    i_ready = 1'b1; i_valid = 1'b1; i_x = 3'd5;
    step();
    i_valid = 1'b0;
    chk("single_valid", {31'b0, o_valid8}, 32'd1);
    chk("single_y", {24'b0, o_y8}, 32'h20);
    chk("single_err", {31'b0, o_err8}, 32'd0);
    step();
    chk("single_drain", {31'b0, o_valid8}, 32'd0);

    // Back-to-back stream 0..7
    for (int k = 0; k < 8; k++) begin
      i_valid = 1'b1; i_x = 3'(k);
      step();
      chk("stream_y", {24'b0, o_y8}, 32'd1 << k);
      chk("stream_count", {30'b0, o_count8}, 32'd1);
      chk("stream_valid", {31'b0, o_valid8}, 32'd1);
    end
    i_valid = 1'b0;
    step();

    // Backpressure: 3 then 6 while stalled
    i_ready = 1'b0; i_valid = 1'b1; i_x = 3'd3;
    step();
    i_x = 3'd6;
    step();
    i_valid = 1'b0;
    chk("bp_count", {30'b0, o_count8}, 32'd2);
    chk("bp_ready", {31'b0, o_ready8}, 32'd0);
    chk("bp_y", {24'b0, o_y8}, 32'h08);
    step();
    chk("bp_hold", {24'b0, o_y8}, 32'h08);
    i_ready = 1'b1;
    step();
    chk("bp_y2", {24'b0, o_y8}, 32'h40);
    chk("bp_ready2", {31'b0, o_ready8}, 32'd1);
    step();
    chk("bp_empty", {31'b0, o_valid8}, 32'd0);

    // Out-of-range indices on the W=6 instance
    i_valid = 1'b1; i_x = 3'd6;
    step();
    chk("rng6_y", {26'b0, o_y6}, 32'd0);
    chk("rng6_err", {31'b0, o_err6}, 32'd1);
    i_x = 3'd7;
    step();
    chk("rng7_y", {26'b0, o_y6}, 32'd0);
    chk("rng7_err", {31'b0, o_err6}, 32'd1);
    i_x = 3'd5;
    step();
    chk("rng5_y", {26'b0, o_y6}, 32'h20);
    chk("rng5_err", {31'b0, o_err6}, 32'd0);
    i_valid = 1'b0;
    step();

    // Reset while FULL
    i_ready = 1'b0; i_valid = 1'b1; i_x = 3'd1;
    step();
    i_x = 3'd2;
    step();
    i_valid = 1'b0;
    chk("full_count", {30'b0, o_count8}, 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, o_valid8}, 32'd0);
    chk("mid_rst_y", {24'b0, o_y8}, 32'd0);
    chk("mid_rst_ready", {31'b0, o_ready8}, 32'd1);
    chk("mid_rst_count", {30'b0, o_count8}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 3) != 0);
      i_x     = 3'($urandom_range(0, 7));
      step();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    step();
    step();
    step();
    chk("final_empty8", {31'b0, o_valid8}, 32'd0);
    chk("final_empty6", {31'b0, o_valid6}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
